// File: rtl/add_tree_acc_if.sv
// rtl/add_tree_acc_if.sv - beat input / result output bundle for add_tree_acc
// Purpose: groups the input beat handshake and the result handshake.
// Ports (signals):
//   in_valid/in_ready/in_first/in_last/in_data : operand beat stream
//   out_valid/out_ready/out_sum/out_ovf        : packet result stream
// Modports: master drives beats and out_ready; slave is the accumulator.
interface add_tree_acc_if #(
  parameter int W     = 16,
  parameter int N     = 8,
  parameter int GUARD = 4
);
  localparam int OW = W + $clog2(N) + GUARD;

  logic          in_valid;
  logic          in_ready;
  logic          in_first;
  logic          in_last;
  logic [N*W-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_sum;
  logic          out_ovf;

  modport master (
    output in_valid, in_first, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_first, in_last, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/add_tree_acc.sv
// rtl/add_tree_acc.sv - pipelined adder tree with packet accumulator
// Purpose: sums N unsigned W-bit operands per beat through a log2(N)-stage
//   registered adder tree, then accumulates beat sums per packet and emits
//   one OW-bit result (OW = W + log2(N) + GUARD) per packet.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : add_tree_acc_if.slave (beat input, result output)
// Build option: define ADD_TREE_ACC_SAT_EN to saturate out_sum to all-ones
//   when out_ovf is set; otherwise out_sum wraps modulo 2^OW.
module add_tree_acc #(
  parameter int W     = 16,
  parameter int N     = 8,
  parameter int GUARD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  add_tree_acc_if.slave bus
);
  localparam int L  = $clog2(N);
  localparam int TW = W + L;
  localparam int OW = TW + GUARD;

  // Tree registers share the final width; stage s only uses entries 0..(N>>s)-1.
  logic [TW-1:0] r_tree [1:L][N];
  logic [L:1]    r_vld;
  logic [L:1]    r_fst;
  logic [L:1]    r_lst;

  logic [OW-1:0] r_acc;
  logic          r_ovf;
  logic          r_open;
  logic          r_out_valid;
  logic [OW-1:0] r_out_sum;
  logic          r_out_ovf;

  logic          w_stall;
  logic          w_start;
  logic [OW:0]   w_tree_ext;
  logic [OW:0]   w_acc_nxt;
  logic          w_ovf_nxt;
  logic [OW-1:0] w_out_sum;

  assign w_stall       = r_out_valid && !bus.out_ready;
  assign bus.in_ready  = !w_stall;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_ovf   = r_out_ovf;

  // A beat sum restarts the accumulator when it opens a packet or when no
  // packet is open (e.g. first beat after reset without in_first).
  assign w_start    = r_fst[L] || !r_open;
  assign w_tree_ext = {{(GUARD + 1){1'b0}}, r_tree[L][0]};
  assign w_acc_nxt  = w_start ? w_tree_ext : ({1'b0, r_acc} + w_tree_ext);
  // Overflow is sticky across the packet: any carry out of bit OW-1.
  assign w_ovf_nxt  = !w_start && (r_ovf || w_acc_nxt[OW]);

`ifdef ADD_TREE_ACC_SAT_EN
  assign w_out_sum = w_ovf_nxt ? {OW{1'b1}} : w_acc_nxt[OW-1:0];
`else
  assign w_out_sum = w_acc_nxt[OW-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 1; s <= L; s++) begin
        for (int k = 0; k < N; k++) begin
          r_tree[s][k] <= '0;
        end
      end
      r_vld       <= '0;
      r_fst       <= '0;
      r_lst       <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_open      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (!w_stall) begin
      // Stage 1: pairwise sums of the incoming operands.
      r_vld[1] <= bus.in_valid;
      r_fst[1] <= bus.in_first;
      r_lst[1] <= bus.in_last;
      for (int k = 0; k < N / 2; k++) begin
        r_tree[1][k] <= {{L{1'b0}}, bus.in_data[(2*k)*W +: W]}
                      + {{L{1'b0}}, bus.in_data[(2*k+1)*W +: W]};
      end
      // Stages 2..L: halve the operand count each stage.
      for (int s = 2; s <= L; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_fst[s] <= r_fst[s-1];
        r_lst[s] <= r_lst[s-1];
        for (int k = 0; k < (N >> s); k++) begin
          r_tree[s][k] <= r_tree[s-1][2*k] + r_tree[s-1][2*k+1];
        end
      end

      if (r_vld[L]) begin
        r_acc  <= w_acc_nxt[OW-1:0];
        r_ovf  <= w_ovf_nxt;
        r_open <= !r_lst[L];
      end

      // Not stalled means the held result (if any) transfers this edge.
      r_out_valid <= r_vld[L] && r_lst[L];
      if (r_vld[L] && r_lst[L]) begin
        r_out_sum <= w_out_sum;
        r_out_ovf <= w_ovf_nxt;
      end
    end
  end
endmodule
